// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Round-robin arbiter sharing the single request port of the cache between
// NUM_REQ requesters. One transaction is in flight at a time. The cache
// enables are held through miss stalls until completion. A watchdog aborts
// transactions that never complete, and a saturating counter tracks miss-stall
// cycles.
module cache_req_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int TIMEOUT          = 255
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0]                       req_write,
    input  logic [NUM_REQ-1:0][RAM_ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]        req_write_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [NUM_REQ-1:0]                       resp_valid,
    output logic [DATA_BITS-1:0]                     resp_data,
    output logic                                     resp_error,
    output logic [RAM_ADDRESS_BITS-1:0]              address,
    output logic                                     read_en,
    output logic                                     write_en,
    output logic [DATA_BITS-1:0]                     write_data,
    input  logic                                     valid,
    input  logic                                     miss,
    input  logic [DATA_BITS-1:0]                     read_data,
    output logic [15:0]                              stall_count
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int IDX1_W = IDX_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                      state_r;
    logic [IDX_W-1:0]            rr_ptr_r;
    logic [IDX_W-1:0]            owner_r;
    logic [WAIT_W-1:0]           wait_cnt_r;
    logic [15:0]                 stall_count_r;
    logic [RAM_ADDRESS_BITS-1:0] address_r;
    logic [DATA_BITS-1:0]        write_data_r;
    logic                        read_en_r;
    logic                        write_en_r;
    logic [NUM_REQ-1:0]          resp_valid_r;
    logic [DATA_BITS-1:0]        resp_data_r;
    logic                        resp_error_r;

    logic [IDX_W-1:0]            grant_s;
    logic [IDX_W-1:0]            next_ptr_s;
    logic                        any_valid_s;
    logic                        done_s;
    logic                        timeout_s;
    logic [NUM_REQ-1:0]          req_ready_s;

    // First requester with req_valid set, searching upward from ptr with wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0]  pick_v;
        logic [IDX1_W-1:0] idx_v;
        logic              found_v;
        pick_v  = {IDX_W{1'b0}};
        found_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = {1'b0, ptr} + IDX1_W'(i);
            if (idx_v >= IDX1_W'(NUM_REQ)) begin
                idx_v = idx_v - IDX1_W'(NUM_REQ);
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && vld[idx_v[IDX_W-1:0]]) begin
                pick_v  = idx_v[IDX_W-1:0];
                found_v = 1'b1;
            end else begin
                pick_v  = pick_v;
            end
        end
        return pick_v;
    endfunction

    // Grant selection, transaction end conditions and next round-robin pointer.
    always_comb begin
        any_valid_s = |req_valid;
        grant_s     = rr_pick(req_valid, rr_ptr_r);
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        if (state_r == ST_BUSY) begin
            done_s    = valid && !miss;
            timeout_s = !(valid && !miss) && (wait_cnt_r == WAIT_LAST);
        end else begin
            done_s    = 1'b0;
            timeout_s = 1'b0;
        end
        if (owner_r == IDX_LAST) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = owner_r + IDX_W'(1);
        end
    end

    // Accept strobe: combinational one-hot to the winning requester while idle.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if ((state_r == ST_IDLE) && !reset && any_valid_s) begin
            req_ready_s = ONE_HOT_0 << grant_s;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Arbitration FSM with registered cache-side and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {IDX_W{1'b0}};
            owner_r      <= {IDX_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
            address_r    <= {RAM_ADDRESS_BITS{1'b0}};
            write_data_r <= {DATA_BITS{1'b0}};
            read_en_r    <= 1'b0;
            write_en_r   <= 1'b0;
            resp_valid_r <= {NUM_REQ{1'b0}};
            resp_data_r  <= {DATA_BITS{1'b0}};
            resp_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= {NUM_REQ{1'b0}};
                    resp_data_r  <= {DATA_BITS{1'b0}};
                    resp_error_r <= 1'b0;
                    if (any_valid_s) begin
                        address_r    <= req_address[grant_s];
                        write_data_r <= req_write_data[grant_s];
                        write_en_r   <= req_write[grant_s];
                        read_en_r    <= ~req_write[grant_s];
                        owner_r      <= grant_s;
                        wait_cnt_r   <= {WAIT_W{1'b0}};
                        state_r      <= ST_BUSY;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    if (done_s || timeout_s) begin
                        // Completion takes priority over a coinciding timeout.
                        resp_valid_r <= ONE_HOT_0 << owner_r;
                        resp_error_r <= !done_s;
                        if (done_s && !write_en_r) begin
                            resp_data_r <= read_data;
                        end else begin
                            resp_data_r <= {DATA_BITS{1'b0}};
                        end
                        address_r    <= {RAM_ADDRESS_BITS{1'b0}};
                        write_data_r <= {DATA_BITS{1'b0}};
                        read_en_r    <= 1'b0;
                        write_en_r   <= 1'b0;
                        rr_ptr_r     <= next_ptr_s;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= {NUM_REQ{1'b0}};
                        resp_data_r  <= {DATA_BITS{1'b0}};
                        resp_error_r <= 1'b0;
                        state_r      <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of busy cycles spent in a miss stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 16'h0000;
        end else if ((state_r == ST_BUSY) && miss && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign req_ready   = req_ready_s;
    assign resp_valid  = resp_valid_r;
    assign resp_data   = resp_data_r;
    assign resp_error  = resp_error_r;
    assign address     = address_r;
    assign read_en     = read_en_r;
    assign write_en    = write_en_r;
    assign write_data  = write_data_r;
    assign stall_count = stall_count_r;

endmodule
